// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: arbitrates one SECDED-protected array port between a host
// requester and a background scrubber. The scrubber visits every address in
// turn, rewrites words that come back with a correctable error, and logs
// correctable/uncorrectable events in saturating counters plus a sticky irq.
module ecc_scrub_ctrl #(
  parameter int DATA_W         = 57,
  parameter int ADDR_W         = 6,
  parameter int DEPTH          = 64,
  parameter int SCRUB_INTERVAL = 256,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scrub_enable,
  input  logic              err_clr,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_dbl_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_sgl_err,
  input  logic              mem_dbl_err,
  output logic [15:0]       corr_count,
  output logic [15:0]       uncorr_count,
  output logic [ADDR_W-1:0] last_err_addr,
  output logic              err_irq
);

  localparam int INT_W = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [INT_W-1:0]  INT_LAST  = INT_W'(SCRUB_INTERVAL - 1);
  localparam logic [STV_W-1:0]  STV_MAX   = STV_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_SCRUB_CHK = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [INT_W-1:0]  r_interval_cnt;
  logic              r_scrub_pending;
  logic [STV_W-1:0]  r_starve_cnt;
  logic [ADDR_W-1:0] r_scrub_addr;
  logic              r_host_rvalid;
  logic [ADDR_W-1:0] r_host_addr;
  logic [15:0]       r_corr_count;
  logic [15:0]       r_uncorr_count;
  logic [ADDR_W-1:0] r_last_err_addr;
  logic              r_err_irq;

  logic              w_in_idle;
  logic              w_in_chk;
  logic              w_scrub_issue;
  logic              w_host_gnt;
  logic              w_chk;
  logic              w_corr_evt;
  logic              w_uncorr_evt;
  logic [ADDR_W-1:0] w_evt_addr;

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_in_chk  = (r_state == ST_SCRUB_CHK);

  // The scrub wins when the host is quiet, or once the host has had its quota
  // of grants while the scrub was waiting.
  assign w_scrub_issue = w_in_idle && r_scrub_pending &&
                         (!host_req || (r_starve_cnt == STV_MAX));
  assign w_host_gnt    = w_in_idle && !w_scrub_issue && host_req;

  // Read responses never overlap: a scrub check cycle always follows a cycle
  // with no host grant, so one shared error path serves both sources.
  assign w_chk        = w_in_chk || r_host_rvalid;
  assign w_uncorr_evt = w_chk && mem_dbl_err;
  assign w_corr_evt   = w_chk && mem_sgl_err && !mem_dbl_err;
  assign w_evt_addr   = w_in_chk ? r_scrub_addr : r_host_addr;

  // State register.
  // NOTE: clocked processes use non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: a scrub check always lasts exactly one cycle.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (w_scrub_issue) w_state_nxt = ST_SCRUB_CHK;
      ST_SCRUB_CHK: w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: drives the single array port from the scrubber or the host.
  // Reset gates the strobes so an abandoned scrub check never writes back.
  always_comb begin
    host_gnt  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (w_scrub_issue) begin
            mem_en   = 1'b1;
            mem_addr = r_scrub_addr;
          end else if (w_host_gnt) begin
            host_gnt  = 1'b1;
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
          end
        end
        ST_SCRUB_CHK: begin
          // Corrected data goes straight back; uncorrectable words are left.
          if (mem_sgl_err && !mem_dbl_err) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_scrub_addr;
            mem_wdata = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Interval timer: counts only while no scrub is waiting.
  always_ff @(posedge clock) begin
    if (reset || !scrub_enable) begin
      r_interval_cnt  <= '0;
      r_scrub_pending <= 1'b0;
    end else if (w_scrub_issue) begin
      r_scrub_pending <= 1'b0;
    end else if (!r_scrub_pending) begin
      if (r_interval_cnt == INT_LAST) begin
        r_interval_cnt  <= '0;
        r_scrub_pending <= 1'b1;
      end else begin
        r_interval_cnt <= r_interval_cnt + INT_W'(1);
      end
    end
  end

  // Starvation counter: host grants taken while a scrub is waiting.
  always_ff @(posedge clock) begin
    if (reset || w_scrub_issue)                                   r_starve_cnt <= '0;
    else if (w_host_gnt && r_scrub_pending && r_starve_cnt != STV_MAX) r_starve_cnt <= r_starve_cnt + STV_W'(1);
  end

  // Scrub address advances after every check, wrapping at the last word.
  always_ff @(posedge clock) begin
    if (reset)                   r_scrub_addr <= '0;
    else if (w_in_chk)           r_scrub_addr <= (r_scrub_addr == ADDR_LAST) ? '0 : r_scrub_addr + ADDR_W'(1);
  end

  // Host read tracking: data is valid the cycle after a read grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_host_rvalid <= 1'b0;
      r_host_addr   <= '0;
    end else begin
      r_host_rvalid <= w_host_gnt && !host_we;
      if (w_host_gnt) r_host_addr <= host_addr;
    end
  end

  // Error log: saturating counters, last error address and sticky irq.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_corr_count    <= '0;
      r_uncorr_count  <= '0;
      r_last_err_addr <= '0;
      r_err_irq       <= 1'b0;
    end else begin
      if (w_corr_evt && r_corr_count != 16'hFFFF)     r_corr_count   <= r_corr_count + 16'd1;
      if (w_uncorr_evt && r_uncorr_count != 16'hFFFF) r_uncorr_count <= r_uncorr_count + 16'd1;
      if (w_corr_evt || w_uncorr_evt)                 r_last_err_addr <= w_evt_addr;
      // A new uncorrectable error outranks a simultaneous clear.
      if (w_uncorr_evt) r_err_irq <= 1'b1;
      else if (err_clr) r_err_irq <= 1'b0;
    end
  end

  // The array returns data one cycle after the strobe, so read data is passed
  // through during the registered valid cycle and held at zero otherwise.
  assign host_rvalid   = r_host_rvalid;
  assign host_rdata    = r_host_rvalid ? mem_rdata : '0;
  assign host_dbl_err  = r_host_rvalid && mem_dbl_err;
  assign corr_count    = r_corr_count;
  assign uncorr_count  = r_uncorr_count;
  assign last_err_addr = r_last_err_addr;
  assign err_irq       = r_err_irq;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl: drives ecc_scrub_ctrl against a behavioural memory with
// per-address error injection; host read results go through a scoreboard.
module tb_ecc_scrub_ctrl;

  logic        clock;
  logic        reset;
  logic        scrub_enable;
  logic        err_clr;
  logic        host_req;
  logic        host_we;
  logic [5:0]  host_addr;
  logic [56:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [56:0] host_rdata;
  logic        host_dbl_err;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [56:0] mem_wdata;
  logic [56:0] mem_rdata;
  logic        mem_sgl_err;
  logic        mem_dbl_err;
  logic [15:0] corr_count;
  logic [15:0] uncorr_count;
  logic [5:0]  last_err_addr;
  logic        err_irq;

  ecc_scrub_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .scrub_enable  (scrub_enable),
    .err_clr       (err_clr),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_gnt      (host_gnt),
    .host_rvalid   (host_rvalid),
    .host_rdata    (host_rdata),
    .host_dbl_err  (host_dbl_err),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_sgl_err   (mem_sgl_err),
    .mem_dbl_err   (mem_dbl_err),
    .corr_count    (corr_count),
    .uncorr_count  (uncorr_count),
    .last_err_addr (last_err_addr),
    .err_irq       (err_irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural array: one-cycle read latency, errors injected per address.
  logic [56:0] mem_arr [64];
  logic [63:0] inj_sgl;
  logic [63:0] inj_dbl;

  always @(posedge clock) begin
    mem_sgl_err <= 1'b0;
    mem_dbl_err <= 1'b0;
    if (mem_en && !mem_we) begin
      mem_rdata   <= mem_arr[mem_addr];
      mem_sgl_err <= inj_sgl[mem_addr];
      mem_dbl_err <= inj_dbl[mem_addr];
    end
    if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
  end

  // Scoreboard: expected host read results queued at grant, checked at rvalid.
  typedef struct packed {
    logic [56:0] data;
    logic        dbl;
  } exp_t;

  exp_t        sb_q [$];
  logic [56:0] exp_mem [64];

  initial begin
    forever begin
      @(negedge clock);
      if (host_rvalid) begin
        if (sb_q.size() == 0) begin
          check("rvalid_unexpected", 64'(host_rvalid), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("host_rdata", 64'(host_rdata), 64'(e.data));
          check("host_dbl_err", 64'(host_dbl_err), 64'(e.dbl));
        end
      end
      if (host_gnt && !host_we) sb_q.push_back('{data: exp_mem[host_addr], dbl: inj_dbl[host_addr]});
      if (host_gnt && host_we)  exp_mem[host_addr] = host_wdata;
    end
  end

  // Issue one host access and wait (bounded) for its grant; returns in the
  // cycle after the grant with the request dropped.
  task automatic host_op(input logic we, input logic [5:0] addr, input logic [56:0] data);
    logic got;
    got = 1'b0;
    @(posedge clock); #1;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = data;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (host_gnt) begin got = 1'b1; break; end
    end
    check("host_gnt_seen", 64'(got), 64'd1);
    @(posedge clock); #1;
    host_req = 1'b0;
  endtask

  // Wait (bounded) for the next scrub read strobe; returns at its negedge.
  task automatic wait_scrub(output logic [5:0] a, output logic ok);
    ok = 1'b0;
    a  = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (mem_en && !mem_we && !host_gnt) begin
        ok = 1'b1;
        a  = mem_addr;
        break;
      end
    end
  endtask

  initial begin
    logic [5:0] sa;
    logic       ok;
    logic [5:0] ea;
    int         n;
    logic       seen;

    reset = 1'b1; scrub_enable = 1'b1; err_clr = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    inj_sgl = '0; inj_dbl = '0;

    // Reset values
    @(posedge clock);
    @(negedge clock);
    check("rst_corr", 64'(corr_count), 64'd0);
    check("rst_uncorr", 64'(uncorr_count), 64'd0);
    check("rst_last_addr", 64'(last_err_addr), 64'd0);
    check("rst_irq", 64'(err_irq), 64'd0);
    check("rst_rvalid", 64'(host_rvalid), 64'd0);
    check("rst_rdata", 64'(host_rdata), 64'd0);
    check("rst_dbl", 64'(host_dbl_err), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 1: first scrub read exactly SCRUB_INTERVAL cycles after release; wrap
    repeat (255) @(posedge clock);
    @(negedge clock);
    check("scrub_early", 64'(mem_en), 64'd0);
    @(posedge clock);
    @(negedge clock);
    check("scrub_first_en", 64'(mem_en), 64'd1);
    check("scrub_first_we", 64'(mem_we), 64'd0);
    check("scrub_first_addr", 64'(mem_addr), 64'd0);
    for (int k = 1; k <= 64; k++) begin
      wait_scrub(sa, ok);
      check("scrub_seen", 64'(ok), 64'd1);
      ea = 6'(k % 64);
      check("scrub_addr_seq", 64'(sa), 64'(ea));
    end

    // 2: correctable error at address 5 is written back next cycle
    host_op(1'b1, 6'd5, 57'h1);
    inj_sgl[5] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_scrub(sa, ok);
      if (!ok || sa == 6'd5) break;
    end
    check("sgl_scrub_seen", 64'(ok), 64'd1);
    check("sgl_scrub_addr", 64'(sa), 64'd5);
    @(negedge clock);
    check("wb_en", 64'(mem_en), 64'd1);
    check("wb_we", 64'(mem_we), 64'd1);
    check("wb_addr", 64'(mem_addr), 64'd5);
    check("wb_wdata", 64'(mem_wdata), 64'h1);
    @(negedge clock);
    check("corr_after_sgl", 64'(corr_count), 64'd1);
    check("last_addr_sgl", 64'(last_err_addr), 64'd5);
    check("irq_after_sgl", 64'(err_irq), 64'd0);
    inj_sgl[5] = 1'b0;

    // 3: uncorrectable error at address 9, then err_clr versus a new error
    host_op(1'b1, 6'd9, 57'h9999);
    inj_dbl[9] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_scrub(sa, ok);
      if (!ok || sa == 6'd9) break;
    end
    check("dbl_scrub_addr", 64'(sa), 64'd9);
    @(negedge clock);
    check("dbl_no_wb", 64'(mem_en), 64'd0);
    @(negedge clock);
    check("uncorr_after_dbl", 64'(uncorr_count), 64'd1);
    check("irq_after_dbl", 64'(err_irq), 64'd1);
    check("last_addr_dbl", 64'(last_err_addr), 64'd9);
    check("corr_after_dbl", 64'(corr_count), 64'd1);
    host_op(1'b0, 6'd9, '0);
    err_clr = 1'b1;
    @(posedge clock); #1;
    err_clr = 1'b0;
    @(negedge clock);
    check("irq_clr_vs_err", 64'(err_irq), 64'd1);
    check("uncorr_host_rd", 64'(uncorr_count), 64'd2);
    @(posedge clock); #1;
    err_clr = 1'b1;
    @(posedge clock); #1;
    err_clr = 1'b0;
    @(negedge clock);
    check("irq_cleared", 64'(err_irq), 64'd0);
    inj_dbl[9] = 1'b0;

    // 5a: host write then read, data valid the cycle after the grant
    host_op(1'b1, 6'd3, 57'h1ABC);
    host_op(1'b0, 6'd3, '0);
    @(negedge clock);
    check("rd_rvalid", 64'(host_rvalid), 64'd1);
    check("rd_rdata", 64'(host_rdata), 64'h1ABC);
    check("rd_dbl", 64'(host_dbl_err), 64'd0);

    // 4: continuous host traffic with a pending scrub
    repeat (2) @(posedge clock);
    #1 scrub_enable = 1'b0;
    @(posedge clock); #1;
    scrub_enable = 1'b1;
    repeat (256) @(posedge clock);
    #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd3;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (host_gnt) n++;
      else if (mem_en && !mem_we) begin seen = 1'b1; break; end
    end
    check("starve_grants", 64'(n), 64'd16);
    check("starve_forced_scrub", 64'(seen), 64'd1);
    @(negedge clock);
    check("starve_chk_gnt", 64'(host_gnt), 64'd0);
    @(negedge clock);
    check("starve_gnt_resume", 64'(host_gnt), 64'd1);
    @(posedge clock); #1;
    host_req = 1'b0;

    // 5b: correctable counter saturation via host reads of a faulty word
    scrub_enable = 1'b0;
    host_op(1'b1, 6'd7, 57'h77);
    inj_sgl[7] = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd7;
    n = 0;
    for (int i = 0; i < 70000 && n < 65533; i++) begin
      @(negedge clock);
      if (host_gnt) n++;
    end
    @(posedge clock); #1;
    host_req = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("corr_pre_sat", 64'(corr_count), 64'hFFFE);
    @(posedge clock); #1;
    host_req = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clock);
      if (host_gnt) n++;
    end
    @(posedge clock); #1;
    host_req = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("corr_saturated", 64'(corr_count), 64'hFFFF);
    check("last_addr_sat", 64'(last_err_addr), 64'd7);
    check("uncorr_unchanged", 64'(uncorr_count), 64'd2);
    inj_sgl[7] = 1'b0;

    // 6: reset during a scrub check that would write back
    @(posedge clock); #1;
    scrub_enable = 1'b1;
    inj_sgl = '1;
    wait_scrub(sa, ok);
    check("rst_scrub_seen", 64'(ok), 64'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("rst_chk_no_en", 64'(mem_en), 64'd0);
    check("rst_chk_no_we", 64'(mem_we), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    inj_sgl = '0;
    @(negedge clock);
    check("post_rst_corr", 64'(corr_count), 64'd0);
    check("post_rst_uncorr", 64'(uncorr_count), 64'd0);
    check("post_rst_last", 64'(last_err_addr), 64'd0);
    check("post_rst_irq", 64'(err_irq), 64'd0);
    check("post_rst_rvalid", 64'(host_rvalid), 64'd0);
    check("post_rst_mem_en", 64'(mem_en), 64'd0);
    check("post_rst_gnt", 64'(host_gnt), 64'd0);

    repeat (3) @(posedge clock);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
